// File: rtl/spi_reg_slave_if.sv
// Serial pins plus register-file outputs of the SPI register responder.
// frame_err exists only when SPI_SLAVE_ERR_EN is defined.
interface spi_reg_slave_if #(
    parameter int DATA_W = 3
);
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_ss_n;
    logic              spi_miso;
    logic [DATA_W-1:0] t_r_wait;
    logic [DATA_W-1:0] t_g_wait;
    logic              wr_pulse;
`ifdef SPI_SLAVE_ERR_EN
    logic              frame_err;
`endif

    modport slave (
        input  spi_sclk, spi_mosi, spi_ss_n,
        output spi_miso, t_r_wait, t_g_wait, wr_pulse
`ifdef SPI_SLAVE_ERR_EN
        , output frame_err
`endif
    );

    modport master (
        output spi_sclk, spi_mosi, spi_ss_n,
        input  spi_miso, t_r_wait, t_g_wait, wr_pulse
`ifdef SPI_SLAVE_ERR_EN
        , input frame_err
`endif
    );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder with a two-entry register file, oversampled in the clk domain.
// Define SPI_SLAVE_ERR_EN for the frame_err strobe and the abort counter at ADDR 8'h03.
module spi_reg_slave #(
    parameter int                DATA_W      = 3,
    parameter logic [DATA_W-1:0] R_WAIT_INIT = 3'h3,
    parameter logic [DATA_W-1:0] G_WAIT_INIT = 3'h4,
    parameter int                SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            n_rst,
    spi_reg_slave_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_cur, mosi_cur, ss_cur;
    logic                   sclk_rise, sclk_fall, ss_fall;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d, rx_next;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        rd_data;
    logic              cmd_wr_q, cmd_wr_d;
    logic              miso_q, miso_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [DATA_W-1:0] r_wait_q, r_wait_d, g_wait_q, g_wait_d;
`ifdef SPI_SLAVE_ERR_EN
    logic              err_pulse_q, err_pulse_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
`endif

    assign sclk_cur  = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_cur  = mosi_sync_q[SYNC_STAGES-1];
    assign ss_cur    = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_cur & ~sclk_prev_q;
    assign sclk_fall = ~sclk_cur & sclk_prev_q;
    assign ss_fall   = ~ss_cur & ss_prev_q;
    assign rx_next   = {rx_q[6:0], mosi_cur};

    // Read data is chosen from the address byte as it completes.
    always_comb begin
        rd_data = 8'h00;
        case (rx_next)
            8'h00:   rd_data = 8'(r_wait_q);
            8'h01:   rd_data = 8'(g_wait_q);
`ifdef SPI_SLAVE_ERR_EN
            8'h03:   rd_data = err_cnt_q;
`endif
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        cmd_wr_d   = cmd_wr_q;
        miso_d     = miso_q;
        wr_pulse_d = 1'b0;
        r_wait_d   = r_wait_q;
        g_wait_d   = g_wait_q;
`ifdef SPI_SLAVE_ERR_EN
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = 3'd0;
                    rx_d      = 8'h00;
                    if (sclk_rise) begin
                        rx_d      = {7'd0, mosi_cur};
                        bit_cnt_d = 3'd1;
                    end
                end
            end
            CMD, ADDR, DATA: begin
                if (ss_cur) begin
                    // Aborted frame: drop everything collected so far.
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    rx_d      = 8'h00;
                    addr_d    = 8'h00;
                    tx_d      = 8'h00;
                    cmd_wr_d  = 1'b0;
                    miso_d    = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
                end else begin
                    if (sclk_rise) begin
                        rx_d      = rx_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == CMD) begin
                                cmd_wr_d = rx_next[0];
                                state_d  = ADDR;
                            end else if (state_q == ADDR) begin
                                addr_d  = rx_next;
                                tx_d    = rd_data;
                                state_d = DATA;
                            end else begin
                                state_d = DONE;
                                if (cmd_wr_q) begin
                                    if (addr_q == 8'h00) begin
                                        r_wait_d   = rx_next[DATA_W-1:0];
                                        wr_pulse_d = 1'b1;
                                    end else if (addr_q == 8'h01) begin
                                        g_wait_d   = rx_next[DATA_W-1:0];
                                        wr_pulse_d = 1'b1;
                                    end
`ifdef SPI_SLAVE_ERR_EN
                                    else if (addr_q == 8'h03) err_cnt_d = 8'h00;
`endif
                                end
                            end
                        end
                    end
                    // First fall in DATA presents tx[7]; the master samples it on the next rise.
                    if (sclk_fall && state_q == DATA) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
            end
            DONE: begin
                if (ss_cur) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    rx_d      = 8'h00;
                    tx_d      = 8'h00;
                    miso_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            addr_q      <= 8'h00;
            tx_q        <= 8'h00;
            cmd_wr_q    <= 1'b0;
            miso_q      <= 1'b0;
            wr_pulse_q  <= 1'b0;
            r_wait_q    <= R_WAIT_INIT;
            g_wait_q    <= G_WAIT_INIT;
`ifdef SPI_SLAVE_ERR_EN
            err_pulse_q <= 1'b0;
            err_cnt_q   <= 8'h00;
`endif
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.spi_ss_n};
            sclk_prev_q <= sclk_cur;
            ss_prev_q   <= ss_cur;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            cmd_wr_q    <= cmd_wr_d;
            miso_q      <= miso_d;
            wr_pulse_q  <= wr_pulse_d;
            r_wait_q    <= r_wait_d;
            g_wait_q    <= g_wait_d;
`ifdef SPI_SLAVE_ERR_EN
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign bus.spi_miso = (state_q == DATA) & miso_q;
    assign bus.t_r_wait = r_wait_q;
    assign bus.t_g_wait = g_wait_q;
    assign bus.wr_pulse = wr_pulse_q;
`ifdef SPI_SLAVE_ERR_EN
    assign bus.frame_err = err_pulse_q;
`endif
endmodule
